if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Holds the PC and a loadable instruction memory.
- Drives pc4, instruction and flush toward IF/ID.
- Honours hazard stall, branch/jump redirects and debug single-step; detects HALT and freezes fetch permanently until reset.

Parameters:
- NB, 32, datapath/instruction width.
- IMEM_ADDR_W, 8, log2 of instruction-memory depth in words (256 words).
- HALT_WORD, 32'hFFFF_FFFF, encoding of the halt instruction.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  asynchronous reset, active-low.
- i_start  in  1  pulse; leaves LOAD and begins execution.
- i_debug_mode  in  1  1 = PC advances only on cycles with i_step.
- i_step  in  1  step enable, used in debug mode.
- i_stall  in  1  hazard-unit stall; holds PC.
- i_branch_taken  in  1  branch resolved taken in a later stage.
- i_branch_target  in  NB  branch target address.
- i_jump  in  1  jump decoded.
- i_jump_target  in  NB  jump target address.
- i_load_en  in  1  instruction-memory write strobe (LOAD state only).
- i_load_addr  in  IMEM_ADDR_W  word address for load.
- i_load_data  in  NB  instruction word to load.
- o_pc  out  NB  current PC.
- o_pc4  out  NB  o_pc + 4.
- o_instruction  out  NB  fetched instruction.
- o_flush  out  1  to IF/ID flush input.
- o_halt  out  1  fetch halted.
- o_cycles  out  NB  count of PC-advance events since start.

Behaviour:
- States: LOAD, RUN, HALTED. Async reset (i_reset=0) forces LOAD, PC=0, o_cycles=0. Reset mid-RUN or mid-HALTED behaves identically; memory contents are not cleared.
- LOAD:
  - On i_load_en at posedge, imem[i_load_addr] <= i_load_data.
  - i_start -> RUN next cycle, PC stays 0.
  - i_start and i_load_en in the same cycle: the write completes and the state moves to RUN.
- RUN:
  - go = !i_debug_mode | i_step.
  - Fetch is combinational: o_instruction = imem[PC[IMEM_ADDR_W+1:2]]. PC bits above the memory width are ignored, so addresses wrap.
- RUN next-PC priority, evaluated only when go=1:
  1. i_branch_taken -> PC <= i_branch_target, regardless of i_stall, because the older instruction wins.
  2. else if i_stall -> hold.
  3. else if i_jump -> PC <= i_jump_target.
  4. else if o_instruction == HALT_WORD -> hold PC, state <= HALTED.
  5. else PC <= PC + 4.
  - When go=0, everything is held, including redirects. The debug unit must hold redirect inputs until the step.
- o_cycles increments by 1 on every RUN cycle where PC is written (rules 1, 3, 5). It wraps modulo 2^NB.
- HALTED: PC frozen at the HALT address; ignores all inputs except reset; i_load_en is ignored. Load writes are also ignored in RUN.
- Outputs:
  - o_pc4 = o_pc + 4 in all states; carry discarded.
  - o_instruction forced to 0 when state != RUN.
  - o_flush = 1 when state != RUN, so IF/ID captures a NOP and keeps pc4.
  - o_halt = (state == HALTED).
- Reset values: o_pc=0, o_pc4=4, o_instruction=0, o_flush=1, o_halt=0, o_cycles=0.

Test Plan:
1. Load imem[0..2] = 0x20010005, 0x20020007, 0xFFFFFFFF; pulse i_start; debug off -> o_pc 0, 4, 8, then o_halt=1, o_flush=1, o_pc stays 8, o_pc4=12, o_cycles=2.
2. RUN at PC=0x10 with i_stall=1 for 3 cycles -> PC holds 0x10, o_cycles unchanged. Release -> PC 0x14 next cycle.
3. Simultaneous i_stall=1, i_jump=1 (target 0x40), i_branch_taken=1 (target 0x80) -> PC=0x80. Repeat with branch low -> PC holds (stall beats jump).
4. i_debug_mode=1, no i_step for 5 cycles -> PC holds. One i_step pulse -> PC advances by exactly 4, o_cycles +1.
5. Drop i_reset asynchronously mid-cycle while in RUN at PC=0x24 -> outputs immediately return to reset values, state LOAD. Previously loaded memory is still readable after i_start.
6. PC=0x3FC with IMEM_ADDR_W=8 -> next fetch at PC=0x400 reads imem[0] (wrap). A load attempt during RUN does not alter memory.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, loadable instruction memory and the
// LOAD/RUN/HALTED sequencing that feeds the IF/ID pipeline register.
module if_fetch_stage #(
  parameter int unsigned     NB          = 32,
  parameter int unsigned     IMEM_ADDR_W = 8,
  parameter logic [NB-1:0]   HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_debug_mode,
  input  logic                   i_step,
  input  logic                   i_stall,
  input  logic                   i_branch_taken,
  input  logic [NB-1:0]          i_branch_target,
  input  logic                   i_jump,
  input  logic [NB-1:0]          i_jump_target,
  input  logic                   i_load_en,
  input  logic [IMEM_ADDR_W-1:0] i_load_addr,
  input  logic [NB-1:0]          i_load_data,
  output logic [NB-1:0]          o_pc,
  output logic [NB-1:0]          o_pc4,
  output logic [NB-1:0]          o_instruction,
  output logic                   o_flush,
  output logic                   o_halt,
  output logic [NB-1:0]          o_cycles
);

  localparam int unsigned ImemDepth = 2 ** IMEM_ADDR_W;
  localparam logic [NB-1:0] PcInc  = NB'(4);
  localparam logic [NB-1:0] CntInc = NB'(1);

  typedef enum logic [1:0] {StLoad, StRun, StHalted} state_e;

  state_e                 state_q, state_d;
  logic [NB-1:0]          pc_q, pc_d;
  logic [NB-1:0]          cycles_q, cycles_d;
  logic [NB-1:0]          imem [ImemDepth];
  logic [IMEM_ADDR_W-1:0] fetch_addr;
  logic [NB-1:0]          fetch_word;
  logic                   go;
  logic                   pc_adv;
  logic                   mem_we;

  // Upper PC bits are dropped, so fetch addresses wrap around the memory.
  assign fetch_addr = pc_q[IMEM_ADDR_W+1:2];
  assign fetch_word = imem[fetch_addr];
  assign go         = !i_debug_mode || i_step;
  assign mem_we     = (state_q == StLoad) && i_load_en;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cycles_d = cycles_q;
    pc_adv   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (i_start) state_d = StRun;
      end
      StRun: begin
        if (go) begin
          // A taken branch belongs to an older instruction, so it overrides a stall.
          if (i_branch_taken) begin
            pc_d   = i_branch_target;
            pc_adv = 1'b1;
          end else if (i_stall) begin
            pc_d = pc_q;
          end else if (i_jump) begin
            pc_d   = i_jump_target;
            pc_adv = 1'b1;
          end else if (fetch_word == HALT_WORD) begin
            state_d = StHalted;
          end else begin
            pc_d   = pc_q + PcInc;
            pc_adv = 1'b1;
          end
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
    if (pc_adv) cycles_d = cycles_q + CntInc;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= StLoad;
      pc_q     <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cycles_q <= cycles_d;
    end
  end

  // Memory survives reset so a program can be restarted without reloading.
  always_ff @(posedge i_clk) begin
    if (mem_we) imem[i_load_addr] <= i_load_data;
  end

  always_comb begin
    o_pc          = pc_q;
    o_pc4         = pc_q + PcInc;
    o_instruction = (state_q == StRun) ? fetch_word : '0;
    o_flush       = (state_q != StRun);
    o_halt        = (state_q == StHalted);
    o_cycles      = cycles_q;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a behavioural model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_if_fetch_stage;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic        i_debug_mode;
  logic        i_step;
  logic        i_stall;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_jump;
  logic [31:0] i_jump_target;
  logic        i_load_en;
  logic [7:0]  i_load_addr;
  logic [31:0] i_load_data;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;
  logic [31:0] o_instruction;
  logic        o_flush;
  logic        o_halt;
  logic [31:0] o_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_debug_mode    (i_debug_mode),
    .i_step          (i_step),
    .i_stall         (i_stall),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_load_en       (i_load_en),
    .i_load_addr     (i_load_addr),
    .i_load_data     (i_load_data),
    .o_pc            (o_pc),
    .o_pc4           (o_pc4),
    .o_instruction   (o_instruction),
    .o_flush         (o_flush),
    .o_halt          (o_halt),
    .o_cycles        (o_cycles)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Behavioural model: memory array, PC, advance counter and two mode flags.
  logic [31:0] m_mem [256];
  logic [31:0] m_pc     = '0;
  logic [31:0] m_cycles = '0;
  logic        m_run    = 1'b0;
  logic        m_halt   = 1'b0;

  function automatic logic [31:0] m_word(input logic [31:0] pc);
    return m_mem[(pc >> 2) % 256];
  endfunction

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_pc     <= '0;
      m_cycles <= '0;
      m_run    <= 1'b0;
      m_halt   <= 1'b0;
    end else if (!m_run && !m_halt) begin
      if (i_load_en) m_mem[i_load_addr] <= i_load_data;
      if (i_start) m_run <= 1'b1;
    end else if (m_run && (!i_debug_mode || i_step)) begin
      if (i_branch_taken) begin
        m_pc     <= i_branch_target;
        m_cycles <= m_cycles + 1;
      end else if (i_stall) begin
        m_pc <= m_pc;
      end else if (i_jump) begin
        m_pc     <= i_jump_target;
        m_cycles <= m_cycles + 1;
      end else if (m_word(m_pc) == 32'hFFFF_FFFF) begin
        m_run  <= 1'b0;
        m_halt <= 1'b1;
      end else begin
        m_pc     <= m_pc + 4;
        m_cycles <= m_cycles + 1;
      end
    end
  end

  always @(negedge i_clk) begin
    chk("pc", o_pc, m_pc);
    chk("pc4", o_pc4, m_pc + 4);
    chk("instruction", o_instruction, m_run ? m_word(m_pc) : 32'h0);
    chk("flush", {31'b0, o_flush}, {31'b0, !m_run});
    chk("halt", {31'b0, o_halt}, {31'b0, m_halt});
    chk("cycles", o_cycles, m_cycles);
  end

  logic [31:0] prog [3];

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    prog[0] = 32'h2001_0005;
    prog[1] = 32'h2002_0007;
    prog[2] = 32'hFFFF_FFFF;
    i_reset = 1'b0;
    i_start = 1'b0;
    i_debug_mode = 1'b0;
    i_step = 1'b0;
    i_stall = 1'b0;
    i_branch_taken = 1'b0;
    i_branch_target = '0;
    i_jump = 1'b0;
    i_jump_target = '0;
    i_load_en = 1'b0;
    i_load_addr = '0;
    i_load_data = '0;
    #12;
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_pc4", o_pc4, 32'h4);
    chk("rst_instr", o_instruction, 32'h0);
    chk("rst_flush", {31'b0, o_flush}, 32'h1);
    chk("rst_halt", {31'b0, o_halt}, 32'h0);
    chk("rst_cycles", o_cycles, 32'h0);
    i_reset = 1'b1;

    // Load the whole memory: program at words 0..2, filler elsewhere.
    for (int i = 0; i < 256; i++) begin
      i_load_en   = 1'b1;
      i_load_addr = 8'(i);
      i_load_data = (i < 3) ? prog[i] : (32'h1000_0000 | 32'(i));
      tick();
    end
    i_load_en = 1'b0;
    chk("load_pc_held", o_pc, 32'h0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t1_pc0", o_pc, 32'h0);
    chk("t1_instr0", o_instruction, 32'h2001_0005);
    chk("t1_flush_run", {31'b0, o_flush}, 32'h0);
    tick();
    chk("t1_pc4", o_pc, 32'h4);
    tick();
    chk("t1_pc8", o_pc, 32'h8);
    chk("t1_instr_halt", o_instruction, 32'hFFFF_FFFF);
    tick();
    chk("t1_halt", {31'b0, o_halt}, 32'h1);
    chk("t1_flush", {31'b0, o_flush}, 32'h1);
    chk("t1_pc_frozen", o_pc, 32'h8);
    chk("t1_pc4_frozen", o_pc4, 32'hC);
    chk("t1_cycles", o_cycles, 32'h2);
    // Halted: loads, start and redirects are all ignored.
    i_load_en = 1'b1; i_load_addr = 8'd5; i_load_data = 32'h0BAD_0BAD;
    i_start = 1'b1; i_jump = 1'b1; i_jump_target = 32'h40;
    tick();
    tick();
    i_load_en = 1'b0; i_start = 1'b0; i_jump = 1'b0;
    chk("t1_still_halted", o_pc, 32'h8);

    // Restart with the halt word replaced by a NOP.
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    i_load_en = 1'b1; i_load_addr = 8'd2; i_load_data = 32'h0000_0013;
    tick();
    i_load_en = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_pc10", o_pc, 32'h10);
    chk("t2_cycles", o_cycles, 32'h4);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t2_stall_pc", o_pc, 32'h10);
    chk("t2_stall_cycles", o_cycles, 32'h4);
    i_stall = 1'b0;
    tick();
    chk("t2_release_pc", o_pc, 32'h14);
    chk("t2_word5_kept", o_instruction, 32'h1000_0005);

    i_stall = 1'b1; i_jump = 1'b1; i_jump_target = 32'h40;
    i_branch_taken = 1'b1; i_branch_target = 32'h80;
    tick();
    chk("t3_branch_wins", o_pc, 32'h80);
    chk("t3_cycles", o_cycles, 32'h6);
    i_branch_taken = 1'b0;
    tick();
    chk("t3_stall_beats_jump", o_pc, 32'h80);
    i_stall = 1'b0;
    tick();
    i_jump = 1'b0;
    chk("t3_jump", o_pc, 32'h40);

    i_debug_mode = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_debug_hold", o_pc, 32'h40);
    chk("t4_debug_cycles", o_cycles, 32'h7);
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    chk("t4_step_pc", o_pc, 32'h44);
    chk("t4_step_cycles", o_cycles, 32'h8);
    i_debug_mode = 1'b0;

    i_jump = 1'b1; i_jump_target = 32'h24;
    tick();
    i_jump = 1'b0;
    chk("t5_pc24", o_pc, 32'h24);
    #2 i_reset = 1'b0;
    #1;
    chk("t5_async_pc", o_pc, 32'h0);
    chk("t5_async_pc4", o_pc4, 32'h4);
    chk("t5_async_instr", o_instruction, 32'h0);
    chk("t5_async_flush", {31'b0, o_flush}, 32'h1);
    chk("t5_async_cycles", o_cycles, 32'h0);
    #2 i_reset = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t5_mem_kept0", o_instruction, 32'h2001_0005);
    tick();
    chk("t5_mem_kept1", o_instruction, 32'h2002_0007);

    i_jump = 1'b1; i_jump_target = 32'h3FC;
    tick();
    i_jump = 1'b0;
    chk("t6_top_word", o_instruction, 32'h1000_00FF);
    i_load_en = 1'b1; i_load_addr = 8'd0; i_load_data = 32'hDEAD_BEEF;
    tick();
    i_load_en = 1'b0;
    chk("t6_wrap_pc", o_pc, 32'h400);
    chk("t6_wrap_pc4", o_pc4, 32'h404);
    chk("t6_wrap_instr", o_instruction, 32'h2001_0005);
    i_jump = 1'b1; i_jump_target = 32'hFFFF_FFFC;
    tick();
    i_jump = 1'b0;
    chk("t6_pc4_carry", o_pc4, 32'h0);
    tick();
    chk("t6_pc_wrap", o_pc, 32'h0);
    tick();
    @(negedge i_clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
